bam_ctrl_input: RTL and testbench

Conditions the raw board controls for the BAM/VGA design and produces the settings that the BAM generator and the VGA colour stage consume. It synchronises SW and KEY to CLOCK_50 and debounces the two latch keys. It captures the duty cycle and prescaler on clean key presses, derives the duty-cycle percentage, and issues one redraw pulse per accepted change. It sits between the board pins and the BAM and vga_rgb instances.

---
 rtl/bam_pkg.sv | 36 +++
 rtl/key_debounce.sv | 81 ++++++++
 rtl/bam_ctrl_input.sv | 97 +++++++++
 tb/tb_bam_ctrl_input.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/bam_pkg.sv
// Shared types and constants for the BAM/VGA board-control slice.
package bam_pkg;

    // Per-key debounce FSM states
    typedef enum logic [1:0] {
        DB_RELEASED,
        DB_PRESS_WAIT,
        DB_PRESSED,
        DB_RELEASE_WAIT
    } db_state_e;

    // 20 ms of stable samples at 50 MHz
    localparam int DEBOUNCE_DEF = 1_000_000;

    // Switch bank field positions
    localparam int SW_W         = 14;
    localparam int SW_ON        = 0;
    localparam int SW_BAM_ON    = 1;
    localparam int SW_IMG       = 2;
    localparam int SW_PRESC_LSB = 3;
    localparam int SW_PRESC_MSB = 5;
    localparam int SW_DC_LSB    = 6;
    localparam int SW_DC_MSB    = 13;

    localparam int DC_W    = 8;
    localparam int PRESC_W = 3;
    localparam int PCT_W   = 7;

    // floor(d*100/255); 255*100 = 25500 fits in 15 bits
    function automatic logic [PCT_W-1:0] dc_to_pct(input logic [DC_W-1:0] d);
        logic [14:0] prod;
        prod = 15'(d) * 15'd100;
        return PCT_W'(prod / 15'd255);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus debounce FSM for one active-low key.
// Emits a single-cycle press pulse once the key has been low for
// DEBOUNCE_CYCLES consecutive synced samples; releases emit nothing.
module key_debounce
    import bam_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic CLOCK_50,
    input  logic arst,
    input  logic key_n_i,
    output logic press_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    db_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             press_q;
    logic             key_lo;

    assign key_lo  = ~sync_q[1];
    assign press_o = press_q;

    // Synchroniser resets to "released" so reset never looks like a press
    always_ff @(posedge CLOCK_50 or negedge arst) begin
        if (!arst) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], key_n_i};
    end

    // Debounce FSM: counter holds the number of consecutive agreeing samples
    always_ff @(posedge CLOCK_50 or negedge arst) begin
        if (!arst) begin
            state_q <= DB_RELEASED;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            press_q <= 1'b0;
            case (state_q)
                DB_RELEASED: if (key_lo) begin
                    state_q <= DB_PRESS_WAIT;
                    cnt_q   <= CNT_W'(1);
                end
                DB_PRESS_WAIT: begin
                    if (!key_lo) begin
                        state_q <= DB_RELEASED;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= DB_PRESSED;
                        cnt_q   <= '0;
                        press_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DB_PRESSED: if (!key_lo) begin
                    state_q <= DB_RELEASE_WAIT;
                    cnt_q   <= CNT_W'(1);
                end
                DB_RELEASE_WAIT: begin
                    if (key_lo) begin
                        state_q <= DB_PRESSED;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= DB_RELEASED;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= DB_RELEASED;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/bam_ctrl_input.sv
// Board-control conditioning for the BAM/VGA design: synchronised switches,
// debounced latch keys, latched duty/prescaler, percent and redraw pulse.
module bam_ctrl_input
    import bam_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic               CLOCK_50,
    input  logic               arst,
    input  logic [SW_W-1:0]    i_sw,
    input  logic [1:0]         i_key_n,
    output logic               o_device_on,
    output logic               o_bam_enable,
    output logic               o_image_mode,
    output logic [DC_W-1:0]    o_duty_cycle,
    output logic [PRESC_W-1:0] o_presc_mode,
    output logic [PCT_W-1:0]   o_dc_percent,
    output logic               o_redraw,
    output logic               o_redraw_led
);

    logic [SW_W-1:0]    sw_meta_q, sw_s_q;
    logic               on_s;
    logic               ps_press, dc_press;
    logic [DC_W-1:0]    duty_q;
    logic [PRESC_W-1:0] presc_q;
    logic               upd_q;
    logic [PCT_W-1:0]   pct_q;
    logic               redraw_q, led_q;

    assign on_s = sw_s_q[SW_ON];

    // Two-flop switch synchroniser
    always_ff @(posedge CLOCK_50 or negedge arst) begin
        if (!arst) begin
            sw_meta_q <= '0;
            sw_s_q    <= '0;
        end else begin
            sw_meta_q <= i_sw;
            sw_s_q    <= sw_meta_q;
        end
    end

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_presc (
        .CLOCK_50(CLOCK_50), .arst(arst), .key_n_i(i_key_n[0]), .press_o(ps_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_duty (
        .CLOCK_50(CLOCK_50), .arst(arst), .key_n_i(i_key_n[1]), .press_o(dc_press)
    );

    // Latch settings on press pulses; device off clears and discards
    always_ff @(posedge CLOCK_50 or negedge arst) begin
        if (!arst) begin
            duty_q  <= '0;
            presc_q <= '0;
            upd_q   <= 1'b0;
        end else if (!on_s) begin
            duty_q  <= '0;
            presc_q <= '0;
            upd_q   <= 1'b0;
        end else begin
            if (dc_press) duty_q  <= sw_s_q[SW_DC_MSB:SW_DC_LSB];
            if (ps_press) presc_q <= sw_s_q[SW_PRESC_MSB:SW_PRESC_LSB];
            upd_q <= dc_press | ps_press;
        end
    end

    // Percent tracks the latched duty one cycle later, so redraw (delayed
    // from the update) always lands together with the fresh percent
    always_ff @(posedge CLOCK_50 or negedge arst) begin
        if (!arst) begin
            pct_q    <= '0;
            redraw_q <= 1'b0;
            led_q    <= 1'b0;
        end else if (!on_s) begin
            pct_q    <= '0;
            redraw_q <= 1'b0;
            led_q    <= 1'b0;
        end else begin
            pct_q    <= dc_to_pct(duty_q);
            redraw_q <= upd_q;
            if (upd_q) led_q <= ~led_q;
        end
    end

    assign o_device_on  = on_s;
    assign o_bam_enable = on_s & sw_s_q[SW_BAM_ON];
    assign o_image_mode = sw_s_q[SW_IMG];
    assign o_duty_cycle = duty_q;
    assign o_presc_mode = presc_q;
    assign o_dc_percent = pct_q;
    assign o_redraw     = redraw_q;
    assign o_redraw_led = led_q;

endmodule

// File: tb/tb_bam_ctrl_input.sv
// Directed bench for bam_ctrl_input with a short debounce window.
module tb_bam_ctrl_input;

    localparam int D = 4;

    logic        CLOCK_50;
    logic        arst;
    logic [13:0] sw;
    logic [1:0]  key_n;
    logic        dev_on, bam_en, img;
    logic [7:0]  duty;
    logic [2:0]  presc;
    logic [6:0]  pct;
    logic        redraw, led;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int red_hi   = 0;

    bam_ctrl_input #(.DEBOUNCE_CYCLES(D)) dut (
        .CLOCK_50(CLOCK_50), .arst(arst), .i_sw(sw), .i_key_n(key_n),
        .o_device_on(dev_on), .o_bam_enable(bam_en), .o_image_mode(img),
        .o_duty_cycle(duty), .o_presc_mode(presc), .o_dc_percent(pct),
        .o_redraw(redraw), .o_redraw_led(led)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end

    // Count cycles in which redraw is high, sampled just after each edge
    always @(posedge CLOCK_50) begin
        #1;
        if (redraw) red_hi++;
    end

    typedef struct {
        logic [7:0] dc;
        logic [2:0] ps;
        logic [1:0] mask;
        int e_dc;
        int e_ps;
        int e_pct;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [13:0] mk_sw(input logic [7:0] dc, input logic [2:0] ps,
                                          input logic im, input logic bm, input logic on);
        return {dc, ps, im, bm, on};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    // Press keys in mask for low_cyc cycles, then release and let both FSMs settle
    task automatic press(input logic [1:0] mask, input int low_cyc);
        cyc(1);
        key_n = ~mask;
        cyc(low_cyc);
        key_n = 2'b11;
        cyc(D + 8);
    endtask

    initial begin
        int r0;
        logic [7:0] d8;

        // ---- reset with settings applied and duty key held ----
        arst  = 1'b0;
        sw    = 14'h3FC1;
        key_n = 2'b01;
        cyc(3);
        chk("rst_duty", duty, 0);
        chk("rst_pct", pct, 0);
        chk("rst_redraw", redraw, 0);
        chk("rst_led", led, 0);
        chk("rst_dev_on", dev_on, 0);
        chk("rst_presc", presc, 0);
        r0 = red_hi;
        arst = 1'b1;
        cyc(7);
        chk("rst_e7_duty", duty, 255);
        chk("rst_e7_redraw", redraw, 0);
        chk("rst_e7_pct", pct, 0);
        cyc(1);
        chk("rst_e8_redraw", redraw, 1);
        chk("rst_e8_pct", pct, 100);
        chk("rst_e8_led", led, 1);
        cyc(1);
        chk("rst_e9_redraw", redraw, 0);
        key_n = 2'b11;
        cyc(D + 8);
        chk("rst_redraw_cnt", red_hi - r0, 1);
        chk("rst_dev_on1", dev_on, 1);
        chk("rst_bam_en", bam_en, 0);

        // ---- bounce rejection, then a real press ----
        sw = mk_sw(8'd128, 3'd0, 1'b0, 1'b0, 1'b1);
        r0 = red_hi;
        for (int i = 0; i < 3; i++) begin
            key_n = 2'b01; cyc(2);
            key_n = 2'b11; cyc(2);
        end
        cyc(D + 4);
        chk("bounce_duty", duty, 255);
        chk("bounce_redraw", red_hi - r0, 0);
        r0 = red_hi;
        press(2'b10, 10);
        chk("p128_duty", duty, 128);
        chk("p128_pct", pct, 50);
        chk("p128_redraw", red_hi - r0, 1);
        chk("p128_led", led, 0);

        // ---- switch path latency, then both keys in the same cycle ----
        sw = mk_sw(8'd3, 3'd5, 1'b1, 1'b1, 1'b1);
        cyc(1);
        chk("sw_lat1_bam", bam_en, 0);
        cyc(1);
        chk("sw_lat2_bam", bam_en, 1);
        chk("sw_lat2_img", img, 1);
        r0 = red_hi;
        press(2'b11, 10);
        chk("both_presc", presc, 5);
        chk("both_duty", duty, 3);
        chk("both_pct", pct, 1);
        chk("both_redraw", red_hi - r0, 1);
        chk("both_led", led, 1);

        // ---- long hold with bouncy release ----
        sw = mk_sw(8'd10, 3'd5, 1'b0, 1'b0, 1'b1);
        r0 = red_hi;
        cyc(1);
        key_n = 2'b01;
        cyc(100);
        for (int i = 0; i < 2; i++) begin
            key_n = 2'b11; cyc(2);
            key_n = 2'b01; cyc(2);
        end
        key_n = 2'b11;
        cyc(D + 8);
        chk("hold_redraw", red_hi - r0, 1);
        chk("hold_duty", duty, 10);
        chk("hold_pct", pct, 3);
        chk("hold_led", led, 0);

        // ---- device switched off while a latch is in flight ----
        sw = mk_sw(8'd77, 3'd2, 1'b0, 1'b0, 1'b1);
        r0 = red_hi;
        cyc(1);
        key_n = 2'b01;           // edge 1 follows
        cyc(5);                  // after edge 5
        sw[0] = 1'b0;            // synced low only after edge 7
        cyc(3);                  // after edge 8
        chk("off_redraw_now", redraw, 0);
        chk("off_duty", duty, 0);
        chk("off_presc", presc, 0);
        chk("off_pct", pct, 0);
        chk("off_dev_on", dev_on, 0);
        key_n = 2'b11;
        cyc(D + 8);
        chk("off_redraw_cnt", red_hi - r0, 0);
        sw[0] = 1'b1;
        cyc(6);
        chk("on_duty_held", duty, 0);
        chk("on_pct_held", pct, 0);
        chk("on_led_held", led, 0);
        chk("on_redraw_cnt", red_hi - r0, 0);
        press(2'b10, 10);
        chk("on_press_duty", duty, 77);
        chk("on_press_pct", pct, 30);
        chk("on_press_led", led, 1);
        chk("on_press_presc", presc, 0);

        // ---- percent sweep over every duty value ----
        for (int d = 0; d < 256; d++) begin
            d8 = 8'(d);
            sw = mk_sw(d8, 3'd0, 1'b0, 1'b0, 1'b1);
            press(2'b10, D + 2);
            chk($sformatf("sweep_duty_%0d", d), duty, d);
            chk($sformatf("sweep_pct_%0d", d), pct, (d * 100) / 255);
        end

        // ---- table: hand-computed latch/percent vectors (state carries over) ----
        tbl[0] = '{dc: 8'd0,   ps: 3'd6, mask: 2'b01, e_dc: 255, e_ps: 6, e_pct: 100};
        tbl[1] = '{dc: 8'd128, ps: 3'd2, mask: 2'b10, e_dc: 128, e_ps: 6, e_pct: 50};
        tbl[2] = '{dc: 8'd200, ps: 3'd7, mask: 2'b11, e_dc: 200, e_ps: 7, e_pct: 78};
        tbl[3] = '{dc: 8'd1,   ps: 3'd3, mask: 2'b10, e_dc: 1,   e_ps: 7, e_pct: 0};
        tbl[4] = '{dc: 8'd254, ps: 3'd0, mask: 2'b11, e_dc: 254, e_ps: 0, e_pct: 99};
        tbl[5] = '{dc: 8'd51,  ps: 3'd4, mask: 2'b01, e_dc: 254, e_ps: 4, e_pct: 99};
        tbl[6] = '{dc: 8'd100, ps: 3'd1, mask: 2'b10, e_dc: 100, e_ps: 4, e_pct: 39};
        tbl[7] = '{dc: 8'd3,   ps: 3'd3, mask: 2'b10, e_dc: 3,   e_ps: 4, e_pct: 1};
        tbl[8] = '{dc: 8'd3,   ps: 3'd3, mask: 2'b10, e_dc: 3,   e_ps: 4, e_pct: 1};
        for (int i = 0; i < 9; i++) begin
            sw = mk_sw(tbl[i].dc, tbl[i].ps, 1'b0, 1'b0, 1'b1);
            r0 = red_hi;
            press(tbl[i].mask, 10);
            chk($sformatf("tbl%0d_duty", i), duty, tbl[i].e_dc);
            chk($sformatf("tbl%0d_presc", i), presc, tbl[i].e_ps);
            chk($sformatf("tbl%0d_pct", i), pct, tbl[i].e_pct);
            chk($sformatf("tbl%0d_redraw", i), red_hi - r0, 1);
        end

        // ---- async reset mid-debounce, key still held ----
        cyc(1);
        key_n = 2'b01;
        cyc(2);
        #3 arst = 1'b0;
        #1;
        chk("arst_mid_duty", duty, 0);
        chk("arst_mid_dev_on", dev_on, 0);
        cyc(1);
        arst = 1'b1;
        r0 = red_hi;
        cyc(7);
        chk("arst_redeb_redraw_e7", redraw, 0);
        cyc(1);
        chk("arst_redeb_redraw_e8", redraw, 1);
        key_n = 2'b11;
        cyc(D + 8);
        chk("arst_redeb_cnt", red_hi - r0, 1);
        chk("arst_redeb_duty", duty, 3);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
